// File: rtl/sha_trailer_compare.sv
// Store-and-forward digest check: buffers one packet, compares its trailer digest with the
// SHA engine's digest, reports the outcome, then replays the packet. Optional counters: SHA_CMP_STATS_EN.
module sha_trailer_compare #(
    parameter int DEPTH    = 64,
    parameter int DIGEST_W = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [511:0]        inp_data,
    input  logic                inp_valid,
    output logic                inp_ready,
    input  logic [63:0]         inp_keep,
    input  logic [5:0]          inp_id,
    input  logic                inp_last,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                digest_valid,
    output logic                digest_ready,
    output logic                comparison_result,
    output logic                comparison_valid,
    input  logic                comparison_ready,
    output logic [511:0]        out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_keep,
    output logic [5:0]          out_id,
    output logic                out_last
`ifdef SHA_CMP_STATS_EN
    ,
    output logic [31:0]         stat_match,
    output logic [31:0]         stat_mismatch,
    output logic [31:0]         stat_overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_FILL,
        S_WAIT_DIGEST,
        S_COMPARE,
        S_REPORT,
        S_DRAIN
    } state_t;

    state_t              state, state_next;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_addr;
    logic [CW-1:0]       count;
    logic                digest_held, overflow, result;
    logic [DIGEST_W-1:0] exp_digest, digest_reg;
    logic                full, in_fire, dig_fire, out_fire, cmp_fire, wr_en;

    logic [511:0] mem_data [DEPTH];
    logic [63:0]  mem_keep [DEPTH];
    logic [5:0]   mem_id   [DEPTH];
    logic         mem_last [DEPTH];

    // Handshake outputs are gated by reset so they read 0 for as long as reset is held.
    always_comb begin
        inp_ready        = reset && (state == S_FILL);
        digest_ready     = reset && !digest_held &&
                           ((state == S_FILL) || (state == S_WAIT_DIGEST));
        comparison_valid = reset && (state == S_REPORT);
        out_valid        = reset && (state == S_DRAIN);
    end

    assign comparison_result = comparison_valid && result;

    assign in_fire  = inp_valid && inp_ready;
    assign dig_fire = digest_valid && digest_ready;
    assign cmp_fire = comparison_valid && comparison_ready;
    assign out_fire = out_valid && out_ready;
    assign full     = (count == CW'(DEPTH));
    // A last beat arriving on a full buffer replaces the final entry so the replay terminates.
    assign wr_en    = in_fire && (!full || inp_last);
    assign wr_addr  = full ? AW'(DEPTH - 1) : wr_ptr;

    always_comb begin
        out      = '0;
        out_keep = '0;
        out_id   = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out      = mem_data[rd_ptr];
            out_keep = mem_keep[rd_ptr];
            out_id   = mem_id[rd_ptr];
            out_last = mem_last[rd_ptr];
        end
    end

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL:        if (in_fire && inp_last) state_next = S_WAIT_DIGEST;
            S_WAIT_DIGEST: if (digest_held || dig_fire) state_next = S_COMPARE;
            S_COMPARE:     state_next = S_REPORT;
            S_REPORT:      if (cmp_fire) state_next = S_DRAIN;
            S_DRAIN:       if (out_fire && out_last) state_next = S_FILL;
            default:       state_next = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_FILL;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            digest_held <= 1'b0;
            overflow    <= 1'b0;
            result      <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end
            if (in_fire && full && !inp_last)
                overflow <= 1'b1;
            if (dig_fire)
                digest_held <= 1'b1;
            if (state == S_COMPARE)
                result <= (exp_digest != digest_reg) || overflow;
            if (out_fire)
                rd_ptr <= rd_ptr + AW'(1);
            if (out_fire && out_last) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                digest_held <= 1'b0;
                overflow    <= 1'b0;
            end
        end
    end

    // NOTE: buffer and digest holding registers carry no reset; control flags decide when they are read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_data[wr_addr] <= inp_data;
            mem_keep[wr_addr] <= inp_keep;
            mem_id[wr_addr]   <= inp_id;
            mem_last[wr_addr] <= inp_last;
        end
        if (in_fire && inp_last)
            exp_digest <= inp_data[DIGEST_W-1:0];
        if (dig_fire)
            digest_reg <= digest;
    end

`ifdef SHA_CMP_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_match    <= '0;
            stat_mismatch <= '0;
            stat_overflow <= '0;
        end else if (cmp_fire) begin
            if (result)
                stat_mismatch <= stat_mismatch + 32'd1;
            else
                stat_match <= stat_match + 32'd1;
            if (overflow)
                stat_overflow <= stat_overflow + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha_trailer_compare.sv
// Directed bench for sha_trailer_compare: match, late mismatch, overflow, single beat,
// reset during replay and a stalled result handshake, with hand-built expected replays.
module tb_sha_trailer_compare;

    localparam int DEPTH = 4;
    localparam int DW    = 256;

    logic          clock = 1'b0;
    logic          reset;
    logic [511:0]  inp_data;
    logic          inp_valid;
    logic          inp_ready;
    logic [63:0]   inp_keep;
    logic [5:0]    inp_id;
    logic          inp_last;
    logic [DW-1:0] digest;
    logic          digest_valid;
    logic          digest_ready;
    logic          comparison_result;
    logic          comparison_valid;
    logic          comparison_ready;
    logic [511:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_keep;
    logic [5:0]    out_id;
    logic          out_last;

    sha_trailer_compare #(.DEPTH(DEPTH), .DIGEST_W(DW)) dut (
        .clock             (clock),
        .reset             (reset),
        .inp_data          (inp_data),
        .inp_valid         (inp_valid),
        .inp_ready         (inp_ready),
        .inp_keep          (inp_keep),
        .inp_id            (inp_id),
        .inp_last          (inp_last),
        .digest            (digest),
        .digest_valid      (digest_valid),
        .digest_ready      (digest_ready),
        .comparison_result (comparison_result),
        .comparison_valid  (comparison_valid),
        .comparison_ready  (comparison_ready),
        .out               (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_keep          (out_keep),
        .out_id            (out_id),
        .out_last          (out_last)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] pkt_data [8];
    logic [63:0]  pkt_keep [8];
    logic [5:0]   pkt_id   [8];
    logic [511:0] exp_data [8];
    logic [63:0]  exp_keep [8];
    logic [5:0]   exp_id   [8];
    logic         exp_last [8];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Builds an n-beat packet whose last beat carries `low` in bits [255:0]; replay expected identical.
    task automatic make_packet(input int n, input logic [255:0] low, input logic [5:0] id);
        for (int i = 0; i < n; i++) begin
            logic [63:0] w;
            w = {32'hC0DE_0000 | {26'd0, id}, 32'(i) ^ 32'h1357_9BDF};
            pkt_data[i] = {8{w}};
            if (i == n - 1)
                pkt_data[i][255:0] = low;
            pkt_keep[i] = (i == n - 1) ? 64'h0000_FFFF_FFFF_FFFF : '1;
            pkt_id[i]   = id;
            exp_data[i] = pkt_data[i];
            exp_keep[i] = pkt_keep[i];
            exp_id[i]   = id;
            exp_last[i] = (i == n - 1);
        end
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [5:0] id,
                             input logic l, output int acc_cyc);
        int g = 0;
        inp_data  = d;
        inp_keep  = k;
        inp_id    = id;
        inp_last  = l;
        inp_valid = 1'b1;
        while (!inp_ready && g < 50) begin
            step();
            g++;
        end
        check("inp_ready_for_beat", inp_ready, 1'b1);
        step();
        acc_cyc   = cyc;
        inp_valid = 1'b0;
        inp_last  = 1'b0;
    endtask

    task automatic send_packet(input int n, output int last_cyc);
        int c = 0;
        for (int i = 0; i < n; i++)
            send_beat(pkt_data[i], pkt_keep[i], pkt_id[i], (i == n - 1), c);
        last_cyc = c;
    endtask

    // hs_cyc is the cycle in which the handshake is presented (before its edge).
    task automatic send_digest(input logic [DW-1:0] d, output int hs_cyc);
        digest       = d;
        digest_valid = 1'b1;
        check("digest_ready", digest_ready, 1'b1);
        hs_cyc = cyc;
        step();
        digest_valid = 1'b0;
    endtask

    // Result must appear after the WAIT_DIGEST and COMPARE cycles: ref_cyc + 2.
    task automatic wait_result(input logic want, input int ref_cyc, input int hold, input string tag);
        int g = 0;
        while (!comparison_valid && g < 100) begin
            step();
            g++;
        end
        check({tag, "_cmp_valid"}, comparison_valid, 1'b1);
        check({tag, "_latency"}, 512'(cyc - ref_cyc), 512'd2);
        check({tag, "_cmp_result"}, comparison_result, want);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, comparison_valid, 1'b1);
            check({tag, "_hold_result"}, comparison_result, want);
            check({tag, "_hold_out_valid"}, out_valid, 1'b0);
            check({tag, "_hold_inp_ready"}, inp_ready, 1'b0);
        end
        comparison_ready = 1'b1;
        step();
    endtask

    // Consumes n_take replay beats, checking every valid cycle (including stalled ones).
    task automatic drain(input int n_take, input bit toggle, input string tag);
        int got = 0;
        int g   = 0;
        out_ready = toggle ? 1'b0 : 1'b1;
        while (got < n_take && g < 200) begin
            if (out_valid) begin
                check({tag, "_out_data"}, out_data, exp_data[got]);
                check({tag, "_out_keep"}, out_keep, exp_keep[got]);
                check({tag, "_out_id"}, out_id, exp_id[got]);
                check({tag, "_out_last"}, out_last, exp_last[got]);
                if (out_ready) got++;
            end
            step();
            if (toggle) out_ready = ~out_ready;
            g++;
        end
        check({tag, "_beats"}, got, n_take);
        out_ready = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_out_valid"}, out_valid, 1'b0);
        check({tag, "_idle_out_data"}, out_data, 512'd0);
        check({tag, "_idle_inp_ready"}, inp_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int hc;
        reset            = 1'b0;
        inp_data         = '0;
        inp_valid        = 1'b0;
        inp_keep         = '0;
        inp_id           = '0;
        inp_last         = 1'b0;
        digest           = '0;
        digest_valid     = 1'b0;
        comparison_ready = 1'b1;
        out_ready        = 1'b1;
        repeat (3) step();

        check("rst_inp_ready", inp_ready, 1'b0);
        check("rst_digest_ready", digest_ready, 1'b0);
        check("rst_cmp_valid", comparison_valid, 1'b0);
        check("rst_cmp_result", comparison_result, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 512'd0);
        check("rst_out_keep", out_keep, 64'd0);
        check("rst_out_last", out_last, 1'b0);
        reset = 1'b1;
        step();
        check("post_rst_inp_ready", inp_ready, 1'b1);
        check("post_rst_digest_ready", digest_ready, 1'b1);

        // Matching digest delivered before the packet.
        make_packet(4, {32{8'hAB}}, 6'd1);
        send_digest({32{8'hAB}}, hc);
        send_packet(4, lc);
        wait_result(1'b0, lc, 0, "t1");
        drain(4, 1'b0, "t1");
        check_idle("t1");

        // Mismatching digest delivered 5 cycles after the last beat.
        make_packet(4, {32{8'hAB}}, 6'd2);
        send_packet(4, lc);
        repeat (5) step();
        check("t2_no_early_valid", comparison_valid, 1'b0);
        check("t2_inp_ready_low", inp_ready, 1'b0);
        send_digest({{31{8'hAB}}, 8'hAA}, hc);
        wait_result(1'b1, hc, 0, "t2");
        drain(4, 1'b0, "t2");
        check_idle("t2");

        // Six beats into a four-entry buffer: beat 5 dropped, beat 6 replaces entry 3.
        make_packet(6, {32{8'hAB}}, 6'd3);
        exp_data[3] = pkt_data[5];
        exp_keep[3] = pkt_keep[5];
        exp_last[3] = 1'b1;
        send_digest({32{8'hAB}}, hc);
        send_packet(6, lc);
        wait_result(1'b1, lc, 0, "t3");
        drain(4, 1'b0, "t3");
        check_idle("t3");

        // Single-beat packet replayed under a toggling out_ready.
        make_packet(1, {32{8'hCD}}, 6'd4);
        send_digest({32{8'hCD}}, hc);
        send_packet(1, lc);
        wait_result(1'b0, lc, 0, "t4");
        drain(1, 1'b1, "t4");
        check_idle("t4");

        // Reset after two of four replay beats, then a fresh three-beat packet.
        make_packet(4, {32{8'h11}}, 6'd5);
        send_digest({32{8'h11}}, hc);
        send_packet(4, lc);
        wait_result(1'b0, lc, 0, "t5a");
        drain(2, 1'b0, "t5a");
        check("t5_mid_drain_out_valid", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_held_out_valid", out_valid, 1'b0);
        check("t5_rst_held_inp_ready", inp_ready, 1'b0);
        step();
        reset = 1'b1;
        #1;
        check("t5_after_rst_out_valid", out_valid, 1'b0);
        check("t5_after_rst_inp_ready", inp_ready, 1'b1);
        make_packet(3, {32{8'h22}}, 6'd6);
        send_digest({32{8'h22}}, hc);
        send_packet(3, lc);
        wait_result(1'b0, lc, 0, "t5b");
        drain(3, 1'b0, "t5b");
        check_idle("t5b");

        // Result held for 10 cycles with comparison_ready low.
        make_packet(2, {32{8'h33}}, 6'd7);
        comparison_ready = 1'b0;
        send_digest({32{8'h34}}, hc);
        send_packet(2, lc);
        wait_result(1'b1, lc, 10, "t6");
        drain(2, 1'b0, "t6");
        check_idle("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
